// File: rtl/ddr_arb_pkg.sv
// Shared types for the multi-channel DDR arbiter: operation encodings and FSM states.
package ddr_arb_pkg;

    localparam logic [1:0] OPTYPE_READ  = 2'b00;
    localparam logic [1:0] OPTYPE_WRITE = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Channel selector: fixed lowest-index priority or round-robin starting at a
// registered pointer that moves past the winner on each accepted grant.
module rr_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         eligible,
    input  logic                      advance,
    output logic [NUM_CH-1:0]         grant_onehot,
    output logic [$clog2(NUM_CH)-1:0] grant_idx
);

    localparam int GID_W = $clog2(NUM_CH);

    logic [GID_W-1:0] rr_ptr;
    logic             found;
    int               cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = (ARB_MODE != 0) ? (int'(rr_ptr) + off) % NUM_CH : off;
            if (!found && eligible[cand]) begin
                found              = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = GID_W'(cand);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == GID_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ddr_multi_channel_arb.sv
// Multi-channel arbiter onto the single DDR port: one operation in flight,
// with per-channel cancel, burst selection and a WAIT-state watchdog.
module ddr_multi_channel_arb
    import ddr_arb_pkg::*;
#(
    parameter int                 NUM_CH         = 2,
    parameter int                 IDX_W          = 64,
    parameter int                 DATA_W         = 512,
    parameter int                 ARB_MODE       = 1,
    parameter logic [NUM_CH-1:0]  BURST_MASK     = 'b01,
    parameter int                 TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         ch_index_valid,
    output logic [NUM_CH-1:0]         ch_index_ready,
    input  logic [NUM_CH*IDX_W-1:0]   ch_index,
    input  logic [NUM_CH*DATA_W-1:0]  ch_write_data,
    input  logic [NUM_CH*2-1:0]       ch_operation_type,
    input  logic [NUM_CH-1:0]         ch_flush,
    output logic [DATA_W-1:0]         ch_read_data,
    output logic [NUM_CH-1:0]         ch_operation_done,
    output logic                      ddr_chip_enable,
    output logic [IDX_W-1:0]          ddr_index,
    output logic                      ddr_write_enable,
    output logic                      ddr_burst_mode,
    output logic [DATA_W-1:0]         ddr_write_data,
    input  logic [DATA_W-1:0]         ddr_read_data,
    input  logic                      ddr_operation_done,
    input  logic                      ddr_ready,
    output logic                      arb_busy,
    output logic [$clog2(NUM_CH)-1:0] arb_grant_id,
    output logic                      arb_timeout_err
);

    localparam int GID_W = $clog2(NUM_CH);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_e        state, state_next;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant_onehot;
    logic [GID_W-1:0]  grant_idx;
    logic              accept;
    logic              wait_done;
    logic              wd_expire;
    logic              cancel;
    logic [WD_W-1:0]   wd_cnt;

    assign eligible = ch_index_valid & ~ch_flush;
    // Gating with reset_n keeps a requester from seeing an accept that the reset discards.
    assign accept          = reset_n && (state == IDLE) && ddr_ready && (|eligible);
    assign ch_index_ready  = accept ? grant_onehot : '0;
    assign ddr_chip_enable = (state == ISSUE);
    assign arb_busy        = (state != IDLE);
    assign wait_done       = (state == WAIT) && ddr_operation_done;
    assign wd_expire       = (state == WAIT) && !ddr_operation_done &&
                             (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_sel (
        .clock        (clock),
        .reset_n      (reset_n),
        .eligible     (eligible),
        .advance      (accept),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (wait_done || wd_expire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ddr_index         <= '0;
            ddr_write_data    <= '0;
            ddr_write_enable  <= 1'b0;
            ddr_burst_mode    <= 1'b0;
            arb_grant_id      <= '0;
            arb_timeout_err   <= 1'b0;
            ch_read_data      <= '0;
            ch_operation_done <= '0;
            cancel            <= 1'b0;
            wd_cnt            <= '0;
        end else begin
            ch_operation_done <= '0;
            if (accept) begin
                ddr_index        <= ch_index[int'(grant_idx)*IDX_W +: IDX_W];
                ddr_write_data   <= ch_write_data[int'(grant_idx)*DATA_W +: DATA_W];
                ddr_write_enable <= (ch_operation_type[int'(grant_idx)*2 +: 2] == OPTYPE_WRITE);
                ddr_burst_mode   <= BURST_MASK[grant_idx];
                arb_grant_id     <= grant_idx;
                cancel           <= 1'b0;
                wd_cnt           <= '0;
            end
            if (state == ISSUE || state == WAIT) cancel <= cancel | ch_flush[arb_grant_id];
            if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (wd_expire) arb_timeout_err <= 1'b1;
            // A flush landing in the done cycle itself still suppresses the pulse.
            if (wait_done) begin
                if (!ddr_write_enable) ch_read_data <= ddr_read_data;
                if (!(cancel || ch_flush[arb_grant_id])) ch_operation_done[arb_grant_id] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_multi_channel_arb.sv
// Bench for ddr_multi_channel_arb: directed scenarios plus a randomized run
// checked against a timestamp-based transaction model.
module tb_ddr_multi_channel_arb;

    localparam int NC = 3;
    localparam int IW = 16;
    localparam int DW = 32;
    localparam int GW = 2;
    localparam logic [NC-1:0] BURST = 3'b101;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset_n;
    logic [NC-1:0]     ch_index_valid, ch_flush;
    logic [NC*IW-1:0]  ch_index;
    logic [NC*DW-1:0]  ch_write_data;
    logic [NC*2-1:0]   ch_operation_type;
    logic [DW-1:0]     ddr_read_data;
    logic              ddr_operation_done, ddr_ready;

    logic [NC-1:0] ch_index_ready, ch_operation_done;
    logic [DW-1:0] ch_read_data, ddr_write_data;
    logic [IW-1:0] ddr_index;
    logic          ddr_chip_enable, ddr_write_enable, ddr_burst_mode, arb_busy, arb_timeout_err;
    logic [GW-1:0] arb_grant_id;

    logic [NC-1:0] b_index_ready, b_operation_done;
    logic [DW-1:0] b_read_data, b_write_data;
    logic [IW-1:0] b_index;
    logic          b_chip_enable, b_write_enable, b_burst_mode, b_busy, b_timeout_err;
    logic [GW-1:0] b_grant_id;

    int tests_run = 0;
    int tests_failed = 0;

    ddr_multi_channel_arb #(.NUM_CH(NC), .IDX_W(IW), .DATA_W(DW), .ARB_MODE(1),
                            .BURST_MASK(BURST), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset_n(reset_n), .ch_index_valid(ch_index_valid),
        .ch_index_ready(ch_index_ready), .ch_index(ch_index), .ch_write_data(ch_write_data),
        .ch_operation_type(ch_operation_type), .ch_flush(ch_flush), .ch_read_data(ch_read_data),
        .ch_operation_done(ch_operation_done), .ddr_chip_enable(ddr_chip_enable),
        .ddr_index(ddr_index), .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
        .ddr_write_data(ddr_write_data), .ddr_read_data(ddr_read_data),
        .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready), .arb_busy(arb_busy),
        .arb_grant_id(arb_grant_id), .arb_timeout_err(arb_timeout_err));

    ddr_multi_channel_arb #(.NUM_CH(NC), .IDX_W(IW), .DATA_W(DW), .ARB_MODE(0),
                            .BURST_MASK(BURST), .TIMEOUT_CYCLES(8)) dut_fixed (
        .clock(clock), .reset_n(reset_n), .ch_index_valid(ch_index_valid),
        .ch_index_ready(b_index_ready), .ch_index(ch_index), .ch_write_data(ch_write_data),
        .ch_operation_type(ch_operation_type), .ch_flush(ch_flush), .ch_read_data(b_read_data),
        .ch_operation_done(b_operation_done), .ddr_chip_enable(b_chip_enable),
        .ddr_index(b_index), .ddr_write_enable(b_write_enable), .ddr_burst_mode(b_burst_mode),
        .ddr_write_data(b_write_data), .ddr_read_data(ddr_read_data),
        .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready), .arb_busy(b_busy),
        .arb_grant_id(b_grant_id), .arb_timeout_err(b_timeout_err));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [IW-1:0] idx, input logic [DW-1:0] data,
                           input logic [1:0] op);
        ch_index[ch*IW +: IW]        = idx;
        ch_write_data[ch*DW +: DW]   = data;
        ch_operation_type[ch*2 +: 2] = op;
    endtask

    task automatic do_reset();
        reset_n            = 1'b0;
        ch_index_valid     = '0;
        ch_flush           = '0;
        ddr_operation_done = 1'b0;
        ddr_ready          = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [NC+NC+NC+1+IW+1+1+DW+DW+1+GW+1-1:0] outs_a, outs_b;
        reset_n = 1'b0; ch_index_valid = '1; ch_flush = '0; ddr_ready = 1'b1;
        ddr_operation_done = 1'b1; ddr_read_data = 32'hFFFF_FFFF;
        ch_index = '1; ch_write_data = '1; ch_operation_type = '0;
        @(negedge clock);
        outs_a = {ch_index_ready, ch_operation_done, ch_index_ready, ddr_chip_enable, ddr_index,
                  ddr_write_enable, ddr_burst_mode, ddr_write_data, ch_read_data, arb_busy,
                  arb_grant_id, arb_timeout_err};
        outs_b = {b_index_ready, b_operation_done, b_index_ready, b_chip_enable, b_index,
                  b_write_enable, b_burst_mode, b_write_data, b_read_data, b_busy,
                  b_grant_id, b_timeout_err};
        tests_run++;
        if (outs_a !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0", outs_a);
        end
        tests_run++;
        if (outs_b !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs_fixed: got %h required 0", outs_b);
        end
        tick();
        ddr_operation_done = 1'b0;
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(1, 16'h0080, 32'h0, 2'b00);
        ch_index_valid = 3'b010;
        @(negedge clock);
        tests_run++;
        if (ch_index_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL sr_ready: got %b required 010", ch_index_ready);
        end
        tick();
        ch_index_valid = '0;
        @(negedge clock);
        tests_run++;
        if ({ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_index} !== {3'b100, 16'h0080}) begin
            tests_failed++;
            $display("FAIL sr_issue: got ce=%b we=%b burst=%b idx=%h required 1 0 0 0080",
                     ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_index);
        end
        tick();
        ddr_read_data = 32'hABCD_1234; ddr_operation_done = 1'b1;
        tick();
        ddr_read_data = 32'h5555_AAAA; ddr_operation_done = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({ch_operation_done, ch_read_data, arb_busy, arb_grant_id} !== {3'b010, 32'hABCD_1234, 1'b0, 2'd1}) begin
            tests_failed++;
            $display("FAIL sr_done: got done=%b data=%h busy=%b gid=%0d required 010 abcd1234 0 1",
                     ch_operation_done, ch_read_data, arb_busy, arb_grant_id);
        end
        tick();
        @(negedge clock);
        tests_run++;
        if (ch_operation_done !== 3'b000) begin
            tests_failed++;
            $display("FAIL sr_single_pulse: got %b required 000", ch_operation_done);
        end
    endtask

    task automatic test_burst_write();
        tick();
        set_req(0, 16'h0040, 32'hCAFE_F00D, 2'b01);
        ch_index_valid = 3'b001;
        @(negedge clock);
        tests_run++;
        if (ch_index_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL bw_ready: got %b required 001", ch_index_ready);
        end
        tick();
        ch_index_valid = '0;
        set_req(0, 16'h1111, 32'h2222_2222, 2'b00);
        @(negedge clock);
        tests_run++;
        if ({ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_index, ddr_write_data} !==
            {3'b111, 16'h0040, 32'hCAFE_F00D}) begin
            tests_failed++;
            $display("FAIL bw_issue: got ce=%b we=%b burst=%b idx=%h wd=%h required 1 1 1 0040 cafef00d",
                     ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_index, ddr_write_data);
        end
        tick();
        @(negedge clock);
        tests_run++;
        if ({ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_index, ddr_write_data} !==
            {3'b011, 16'h0040, 32'hCAFE_F00D}) begin
            tests_failed++;
            $display("FAIL bw_stable: got ce=%b we=%b burst=%b idx=%h wd=%h required 0 1 1 0040 cafef00d",
                     ddr_chip_enable, ddr_write_enable, ddr_burst_mode, ddr_index, ddr_write_data);
        end
        tick();
        ddr_read_data = 32'h1234_5678; ddr_operation_done = 1'b1;
        tick();
        ddr_operation_done = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({ch_operation_done, ch_read_data} !== {3'b001, 32'hABCD_1234}) begin
            tests_failed++;
            $display("FAIL bw_done: got done=%b data=%h required 001 abcd1234",
                     ch_operation_done, ch_read_data);
        end
    endtask

    task automatic run_pair(input bit fixed_dut);
        logic [NC-1:0] want, got;
        do_reset();
        set_req(0, 16'h0001, 32'h0, 2'b00);
        set_req(1, 16'h0002, 32'h0, 2'b00);
        ch_index_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            want = fixed_dut ? 3'b001 : ((k % 2 == 0) ? 3'b001 : 3'b010);
            got  = fixed_dut ? b_index_ready : ch_index_ready;
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL %s_grant%0d: got %b required %b", fixed_dut ? "fixed" : "rr", k, got, want);
            end
            tick();
            tick();
            ddr_operation_done = 1'b1;
            tick();
            ddr_operation_done = 1'b0;
        end
        ch_index_valid = '0;
    endtask

    task automatic test_rr_fairness();
        run_pair(1'b0);
    endtask

    task automatic test_fixed_priority();
        run_pair(1'b1);
    endtask

    task automatic test_flush();
        do_reset();
        set_req(1, 16'h0099, 32'h0, 2'b00);
        ch_index_valid = 3'b010;
        tick();
        ch_index_valid = '0;
        tick();
        tick();
        ch_flush = 3'b010;
        tick();
        ch_flush = '0; ddr_operation_done = 1'b1;
        tick();
        ddr_operation_done = 1'b0;
        set_req(0, 16'h0033, 32'h0, 2'b00);
        ch_index_valid = 3'b001;
        @(negedge clock);
        tests_run++;
        if ({ch_operation_done, arb_busy, ch_index_ready} !== {3'b000, 1'b0, 3'b001}) begin
            tests_failed++;
            $display("FAIL fl_cancel: got done=%b busy=%b ready=%b required 000 0 001",
                     ch_operation_done, arb_busy, ch_index_ready);
        end
        tick();
        ch_index_valid = '0;
        tick();
        ddr_operation_done = 1'b1;
        tick();
        ddr_operation_done = 1'b0;
        @(negedge clock);
        tests_run++;
        if (ch_operation_done !== 3'b001) begin
            tests_failed++;
            $display("FAIL fl_next_done: got %b required 001", ch_operation_done);
        end
        tick();
        set_req(1, 16'h0077, 32'h0, 2'b00);
        ch_index_valid = 3'b011; ch_flush = 3'b001;
        @(negedge clock);
        tests_run++;
        if (ch_index_ready !== 3'b010) begin
            tests_failed++;
            $display("FAIL fl_idle_mask: got %b required 010", ch_index_ready);
        end
        tick();
        ch_index_valid = '0; ch_flush = '0;
        tick();
        ddr_operation_done = 1'b1; ch_flush = 3'b010;
        tick();
        ddr_operation_done = 1'b0; ch_flush = '0;
        @(negedge clock);
        tests_run++;
        if ({ch_operation_done, arb_busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL fl_same_cycle: got done=%b busy=%b required 000 0", ch_operation_done, arb_busy);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        set_req(0, 16'h0010, 32'h0, 2'b00);
        ch_index_valid = 3'b001;
        tick();
        ch_index_valid = '0;
        for (int w = 1; w <= 8; w++) begin
            tick();
            @(negedge clock);
            tests_run++;
            if ({arb_timeout_err, arb_busy, ch_operation_done} !== {2'b01, 3'b000}) begin
                tests_failed++;
                $display("FAIL wd_wait%0d: got err=%b busy=%b done=%b required 0 1 000",
                         w, arb_timeout_err, arb_busy, ch_operation_done);
            end
        end
        tick();
        @(negedge clock);
        tests_run++;
        if ({arb_timeout_err, arb_busy, ch_operation_done} !== {2'b10, 3'b000}) begin
            tests_failed++;
            $display("FAIL wd_fire: got err=%b busy=%b done=%b required 1 0 000",
                     arb_timeout_err, arb_busy, ch_operation_done);
        end
        tick();
        ddr_operation_done = 1'b1;
        tick();
        ddr_operation_done = 1'b0;
        tick();
        @(negedge clock);
        tests_run++;
        if ({arb_timeout_err, arb_busy, ch_operation_done} !== {2'b10, 3'b000}) begin
            tests_failed++;
            $display("FAIL wd_sticky: got err=%b busy=%b done=%b required 1 0 000",
                     arb_timeout_err, arb_busy, ch_operation_done);
        end
        do_reset();
        @(negedge clock);
        tests_run++;
        if (arb_timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wd_cleared: got %b required 0", arb_timeout_err);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        set_req(1, 16'h0055, 32'h0, 2'b00);
        ch_index_valid = 3'b010;
        tick();
        ch_index_valid = '0;
        tick();
        reset_n = 1'b0; ddr_ready = 1'b0;
        set_req(0, 16'h0066, 32'h0, 2'b00);
        ch_index_valid = 3'b001;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ddr_operation_done = (i == 0);
            @(negedge clock);
            tests_run++;
            if ({ch_index_ready, ch_operation_done, arb_busy, ddr_chip_enable} !== '0) begin
                tests_failed++;
                $display("FAIL rw_quiet%0d: got ready=%b done=%b busy=%b ce=%b required all 0",
                         i, ch_index_ready, ch_operation_done, arb_busy, ddr_chip_enable);
            end
            tick();
        end
        ddr_operation_done = 1'b0; ddr_ready = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ch_index_ready !== 3'b001) begin
            tests_failed++;
            $display("FAIL rw_resume: got %b required 001", ch_index_ready);
        end
        tick();
        ch_index_valid = '0;
    endtask

    task automatic test_random();
        logic [IW-1:0] r_idx[NC];
        logic [DW-1:0] r_data[NC];
        logic [1:0]    r_op[NC];
        logic [NC-1:0] clr, elig, exp_ready, exp_done, done_val;
        logic [IW-1:0] t_idx;
        logic [DW-1:0] t_data, exp_rd;
        logic          t_we, t_burst, cancel_m;
        int rr, issue_at, done_at, free_at, g_cur, last_g, exp_g, c;
        do_reset();
        rr = 0; issue_at = -100; done_at = -100; free_at = 0; g_cur = 0; last_g = 0;
        clr = '0; exp_rd = '0; done_val = '0; cancel_m = 1'b0;
        t_idx = '0; t_data = '0; t_we = 1'b0; t_burst = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ch_index_valid = ch_index_valid & ~clr;
            clr = '0;
            for (int ch = 0; ch < NC; ch++) begin
                if (!ch_index_valid[ch] && $urandom_range(0, 2) == 0) begin
                    r_idx[ch]  = IW'($urandom);
                    r_data[ch] = $urandom;
                    r_op[ch]   = 2'($urandom_range(0, 3));
                    set_req(ch, r_idx[ch], r_data[ch], r_op[ch]);
                    ch_index_valid[ch] = 1'b1;
                end
                ch_flush[ch] = ($urandom_range(0, 7) == 0);
            end
            ddr_ready     = ($urandom_range(0, 3) != 0);
            ddr_read_data = $urandom;
            if (cyc == done_at)                         ddr_operation_done = 1'b1;
            else if (cyc <= issue_at || cyc > done_at)  ddr_operation_done = ($urandom_range(0, 9) == 0);
            else                                        ddr_operation_done = 1'b0;

            elig  = ch_index_valid & ~ch_flush;
            exp_g = -1;
            if (cyc >= free_at && ddr_ready && elig != 0) begin
                for (int off = NC - 1; off >= 0; off--) begin
                    c = (rr + off) % NC;
                    if (elig[c]) exp_g = c;
                end
            end
            exp_ready = (exp_g >= 0) ? (NC'(1) << exp_g) : '0;
            exp_done  = (cyc == done_at + 1) ? done_val : '0;

            @(negedge clock);
            tests_run++;
            if (ch_index_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rnd_ready c%0d: got %b required %b", cyc, ch_index_ready, exp_ready);
            end
            tests_run++;
            if (ddr_chip_enable !== (cyc == issue_at)) begin
                tests_failed++;
                $display("FAIL rnd_ce c%0d: got %b required %b", cyc, ddr_chip_enable, cyc == issue_at);
            end
            if (cyc == issue_at) begin
                tests_run++;
                if ({ddr_index, ddr_write_enable, ddr_burst_mode, ddr_write_data} !==
                    {t_idx, t_we, t_burst, t_data}) begin
                    tests_failed++;
                    $display("FAIL rnd_issue c%0d: got %h %b %b %h required %h %b %b %h", cyc,
                             ddr_index, ddr_write_enable, ddr_burst_mode, ddr_write_data,
                             t_idx, t_we, t_burst, t_data);
                end
            end
            tests_run++;
            if ({ch_operation_done, ch_read_data, arb_busy, arb_grant_id} !==
                {exp_done, exp_rd, (cyc >= issue_at && cyc <= done_at), GW'(last_g)}) begin
                tests_failed++;
                $display("FAIL rnd_state c%0d: got done=%b rd=%h busy=%b gid=%0d required %b %h %b %0d",
                         cyc, ch_operation_done, ch_read_data, arb_busy, arb_grant_id,
                         exp_done, exp_rd, (cyc >= issue_at && cyc <= done_at), last_g);
            end

            if (cyc >= issue_at && cyc <= done_at && ch_flush[g_cur]) cancel_m = 1'b1;
            if (cyc == done_at) begin
                done_val = cancel_m ? '0 : (NC'(1) << g_cur);
                if (!t_we) exp_rd = ddr_read_data;
            end
            if (exp_g >= 0) begin
                g_cur = exp_g; last_g = exp_g;
                t_idx = r_idx[exp_g]; t_data = r_data[exp_g];
                t_we = (r_op[exp_g] == 2'b01); t_burst = BURST[exp_g];
                issue_at = cyc + 1;
                done_at  = issue_at + $urandom_range(1, 5);
                free_at  = done_at + 1;
                cancel_m = 1'b0;
                rr = (exp_g + 1) % NC;
                clr[exp_g] = 1'b1;
            end
            tick();
        end
        ch_index_valid = '0; ch_flush = '0; ddr_operation_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: run did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        ch_index = '0; ch_write_data = '0; ch_operation_type = '0; ddr_read_data = '0;
        test_reset();
        test_single_read();
        test_burst_write();
        test_rr_fairness();
        test_fixed_priority();
        test_flush();
        test_watchdog();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
